// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem req/ready handshake, and feeds IF/ID.
// Optional FETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Clrn,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc4,
   output logic [31:0] inst,
   output logic        ifid_en
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_bubbles
`endif
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_HOLD = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t            state;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   hold_inst;
   logic [XLEN-1:0]   hold_pc4;
   logic [XLEN-1:0]   pc_plus4;
   logic [XLEN-1:0]   target;

   assign pc_plus4 = pc + XLEN'(4);
   assign target   = redirect_pc & ~XLEN'(3);

   // State, PC and hold buffer; imem_addr doubles as the stale-address register while in DROP
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         state     <= S_REQ;
         pc        <= RESET_PC;
         hold_inst <= '0;
         hold_pc4  <= '0;
         imem_req  <= 1'b1;
         imem_addr <= RESET_PC;
      end else if (redirect) begin
         pc       <= target;
         imem_req <= 1'b1;
         if ((state == S_HOLD) || imem_ready) begin
            state     <= S_REQ;
            imem_addr <= target;
         end else begin
            state <= S_DROP;
         end
      end else begin
         case (state)
            S_REQ: begin
               if (imem_ready) begin
                  pc        <= pc_plus4;
                  imem_addr <= pc_plus4;
                  if (stall) begin
                     hold_inst <= imem_rdata;
                     hold_pc4  <= pc_plus4;
                     imem_req  <= 1'b0;
                     state     <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  imem_req <= 1'b1;
                  state    <= S_REQ;
               end
            end
            default: begin
               if (imem_ready) begin
                  imem_addr <= pc;
                  state     <= S_REQ;
               end
            end
         endcase
      end
   end

   // IF/ID inputs are combinational so delivery lands in the same cycle as imem_ready
   always_comb begin
      ifid_en = 1'b0;
      inst    = hold_inst;
      pc4     = hold_pc4;
      if (redirect) begin
         ifid_en = 1'b1;
         inst    = NOP_INST;
         pc4     = '0;
      end else begin
         case (state)
            S_REQ: begin
               inst    = imem_rdata;
               pc4     = pc_plus4;
               ifid_en = imem_ready & ~stall;
            end
            S_HOLD:  ifid_en = ~stall;
            default: ifid_en = 1'b0;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   // Flush NOPs count as bubbles, not fetches
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         perf_fetched <= '0;
         perf_bubbles <= '0;
      end else if (ifid_en && !redirect) begin
         perf_fetched <= perf_fetched + XLEN'(1);
      end else begin
         perf_bubbles <= perf_bubbles + XLEN'(1);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected IF/ID deliveries are queued as stimulus is driven.
module tb_fetch_unit;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] pc4;
   logic [31:0] inst;
   logic        ifid_en;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_bubbles;
`endif

   int n_chk = 0;
   int n_err = 0;
   int exp_fetched = 0;
   int exp_bubbles = 0;
   logic [63:0] sb[$];

   always #5 clk = ~clk;

   // Memory model: word returned is the address scrambled by KEY
   assign imem_rdata = imem_addr ^ KEY;

   fetch_unit #(.RESET_PC(32'h0000_0100), .NOP_INST(32'h0000_0000)) dut (
      .Clk        (clk),
      .Clrn       (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .pc4        (pc4),
      .inst       (inst),
      .ifid_en    (ifid_en)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched(perf_fetched),
      .perf_bubbles(perf_bubbles)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] e_inst, input logic [31:0] e_pc4);
      sb.push_back({e_inst, e_pc4});
   endtask

   // One clock cycle: drive inputs, check handshake outputs mid-cycle, pop a delivery if any
   task automatic cyc(input logic rdy, input logic stl, input logic rdr, input logic [31:0] rpc,
                      input logic ereq, input logic [31:0] eaddr, input logic een);
      logic [63:0] e;
      imem_ready  = rdy;
      stall       = stl;
      redirect    = rdr;
      redirect_pc = rpc;
      @(negedge clk);
      chk("imem_req", 32'(imem_req), 32'(ereq));
      if (ereq) chk("imem_addr", imem_addr, eaddr);
      chk("ifid_en", 32'(ifid_en), 32'(een));
      if (ifid_en) begin
         if (sb.size() == 0) begin
            chk("unexpected_delivery", 32'(1), 32'(0));
         end else begin
            e = sb.pop_front();
            chk("inst", inst, e[63:32]);
            chk("pc4", pc4, e[31:0]);
         end
      end
      if (een && !rdr) exp_fetched++;
      else exp_bubbles++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'(1));
      chk("rst_addr", imem_addr, 32'h0000_0100);
      chk("rst_en", 32'(ifid_en), 32'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Streaming fetch, one per cycle
      push(32'h100 ^ KEY, 32'h104); cyc(1, 0, 0, '0, 1, 32'h100, 1);
      push(32'h104 ^ KEY, 32'h108); cyc(1, 0, 0, '0, 1, 32'h104, 1);
      // Three-cycle stall: 108 buffered, released in the fourth cycle
      push(32'h108 ^ KEY, 32'h10C); cyc(1, 1, 0, '0, 1, 32'h108, 0);
      cyc(1, 1, 0, '0, 0, '0, 0);
      cyc(1, 1, 0, '0, 0, '0, 0);
      cyc(1, 0, 0, '0, 0, '0, 1);
      push(32'h10C ^ KEY, 32'h110); cyc(1, 0, 0, '0, 1, 32'h10C, 1);
      // Redirect with ready=1; low address bits dropped
      push(32'h0, 32'h0); cyc(1, 0, 1, 32'h203, 1, 32'h110, 1);
      push(32'h200 ^ KEY, 32'h204); cyc(1, 0, 0, '0, 1, 32'h200, 1);
      // Redirect while a request is outstanding: stale response is discarded
      cyc(0, 0, 0, '0, 1, 32'h204, 0);
      push(32'h0, 32'h0); cyc(0, 0, 1, 32'h300, 1, 32'h204, 1);
      cyc(0, 0, 0, '0, 1, 32'h204, 0);
      cyc(1, 0, 0, '0, 1, 32'h204, 0);
      push(32'h300 ^ KEY, 32'h304); cyc(1, 0, 0, '0, 1, 32'h300, 1);
      // Redirect in HOLD under stall: flush beats the stall, buffered word is dropped
      cyc(1, 1, 0, '0, 1, 32'h304, 0);
      cyc(1, 1, 0, '0, 0, '0, 0);
      push(32'h0, 32'h0); cyc(1, 1, 1, 32'hFFFF_FFFC, 0, '0, 1);
      // PC wrap at the top of the address space
      push(32'hFFFF_FFFC ^ KEY, 32'h0); cyc(1, 0, 0, '0, 1, 32'hFFFF_FFFC, 1);
      push(32'h0 ^ KEY, 32'h4); cyc(1, 0, 0, '0, 1, 32'h0, 1);
      cyc(0, 0, 0, '0, 1, 32'h4, 0);

      chk("sb_empty", 32'(sb.size()), 32'(0));
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, 32'(exp_fetched));
      chk("perf_bubbles", perf_bubbles, 32'(exp_bubbles));
`endif
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
